// File: rtl/ebus_pkg.sv
// Shared types and helpers for the EBUS data arbiter.
package ebus_pkg;

  localparam int unsigned EBUS_NDRV    = 32;
  localparam int unsigned EBUS_WIDTH   = 36;
  localparam int unsigned EBUS_NSLICE  = 6;
  localparam int unsigned EBUS_TIMEOUT = 255;
  localparam int unsigned EBUS_CNTW    = 8;
  localparam int unsigned EBUS_IDX_W   = $clog2(EBUS_NDRV);

  typedef logic [EBUS_IDX_W-1:0] drv_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } tEbusWd;

  function automatic int unsigned slice_w(int unsigned width, int unsigned nslice);
    return width / nslice;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ebus_slice_pick.sv
// Priority pick for one EBUS slice: lowest enabled driver wins; also reports
// whether the slice is driven, contended, and which driver lost first.
module ebus_slice_pick
  import ebus_pkg::*;
#(
  parameter int unsigned NDRV = EBUS_NDRV,
  parameter int unsigned SW   = 6,
  localparam int unsigned IW  = idx_w(NDRV)
) (
  input  logic [NDRV-1:0]    en,
  input  logic [NDRV*SW-1:0] data,
  output logic [SW-1:0]      win_data_c,
  output logic               driven_c,
  output logic               conflict_c,
  output logic [IW-1:0]      second_idx_c
);

  always_comb begin
    win_data_c   = '0;
    driven_c     = 1'b0;
    conflict_c   = 1'b0;
    second_idx_c = '0;
    for (int unsigned i = 0; i < NDRV; i++) begin
      if (en[i]) begin
        if (!driven_c) begin
          driven_c   = 1'b1;
          win_data_c = data[i*SW +: SW];
        end else if (!conflict_c) begin
          conflict_c   = 1'b1;
          second_idx_c = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ebus_mux_arb.sv
// N-driver, per-slice priority EBUS data mux with sticky contention status
// and a demand/xfer watchdog.
module ebus_mux_arb
  import ebus_pkg::*;
#(
  parameter int unsigned NDRV    = EBUS_NDRV,
  parameter int unsigned WIDTH   = EBUS_WIDTH,
  parameter int unsigned NSLICE  = EBUS_NSLICE,
  parameter int unsigned REG_OUT = 1,
  parameter int unsigned TIMEOUT = EBUS_TIMEOUT,
  parameter int unsigned CNTW    = EBUS_CNTW,
  localparam int unsigned SW     = slice_w(WIDTH, NSLICE),
  localparam int unsigned IW     = idx_w(NDRV)
) (
  input  logic                     clk,
  input  logic                     crobar_l,
  input  logic [NDRV*NSLICE-1:0]   drv_slice_en,
  input  logic [NDRV*WIDTH-1:0]    drv_data,
  input  logic                     demand,
  input  logic                     xfer,
  input  logic                     clr_status,
  output logic [WIDTH-1:0]         ebus_data,
  output logic [NSLICE-1:0]        ebus_driven,
  output logic                     conflict,
  output logic [NSLICE-1:0]        conflict_slice,
  output logic [IW-1:0]            conflict_drv,
  output logic [CNTW-1:0]          conflict_cnt,
  output logic                     timeout,
  output logic                     timeout_flag
);

  localparam int unsigned TW = idx_w(TIMEOUT);

  logic [WIDTH-1:0]  mux_data_c;
  logic [NSLICE-1:0] mux_driven_c;
  logic [NSLICE-1:0] slice_conf_c;
  logic [IW-1:0]     slice_second_c [NSLICE];
  logic              any_conf_c;
  logic [IW-1:0]     first_second_c;

  logic              conflict_q, conflict_d;
  logic [NSLICE-1:0] conflict_slice_q, conflict_slice_d;
  logic [IW-1:0]     conflict_drv_q, conflict_drv_d;
  logic [CNTW-1:0]   conflict_cnt_q, conflict_cnt_d;
  logic              timeout_q, timeout_d;
  logic              timeout_flag_q, timeout_flag_d;
  tEbusWd            wd_state_q, wd_state_d;
  logic [TW-1:0]     wd_cnt_q, wd_cnt_d;

  // Slice 0 is the most significant SW bits of the word (KL bit 0 = MSB).
  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    logic [NDRV-1:0]    en;
    logic [NDRV*SW-1:0] dat;
    logic [SW-1:0]      win;

    for (genvar i = 0; i < NDRV; i++) begin : g_drv
      assign en[i]           = drv_slice_en[i*NSLICE + s];
      assign dat[i*SW +: SW] = drv_data[i*WIDTH + (NSLICE-1-s)*SW +: SW];
    end

    ebus_slice_pick #(
      .NDRV (NDRV),
      .SW   (SW)
    ) u_pick (
      .en           (en),
      .data         (dat),
      .win_data_c   (win),
      .driven_c     (mux_driven_c[s]),
      .conflict_c   (slice_conf_c[s]),
      .second_idx_c (slice_second_c[s])
    );

    assign mux_data_c[(NSLICE-1-s)*SW +: SW] = win;
  end

  assign any_conf_c = |slice_conf_c;

  // Losing driver reported from the lowest-numbered contended slice.
  always_comb begin
    logic found;
    found          = 1'b0;
    first_second_c = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (slice_conf_c[s] && !found) begin
        found          = 1'b1;
        first_second_c = slice_second_c[s];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0]  data_q;
    logic [NSLICE-1:0] driven_q;

    always_ff @(posedge clk or negedge crobar_l) begin
      if (!crobar_l) begin
        data_q   <= '0;
        driven_q <= '0;
      end else begin
        data_q   <= mux_data_c;
        driven_q <= mux_driven_c;
      end
    end

    assign ebus_data   = data_q;
    assign ebus_driven = driven_q;
  end else begin : g_comb_out
    assign ebus_data   = mux_data_c;
    assign ebus_driven = mux_driven_c;
  end

  // Watchdog: bound the time from demand to xfer.
  always_comb begin
    wd_state_d = wd_state_q;
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = 1'b0;
    unique case (wd_state_q)
      IDLE: begin
        if (demand) begin
          wd_cnt_d   = '0;
          wd_state_d = WAIT;
        end
      end
      WAIT: begin
        if (xfer) begin
          wd_state_d = DONE;
        end else if (!demand) begin
          wd_state_d = IDLE;
        end else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d  = 1'b1;
          wd_state_d = DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
      end
      DONE: begin
        if (!demand) wd_state_d = IDLE;
      end
      default: wd_state_d = IDLE;
    endcase
  end

  // Sticky status; a conflict in the clear cycle is captured after the clear.
  always_comb begin
    conflict_d       = conflict_q;
    conflict_slice_d = conflict_slice_q;
    conflict_drv_d   = conflict_drv_q;
    conflict_cnt_d   = conflict_cnt_q;
    timeout_flag_d   = timeout_flag_q;
    if (clr_status) begin
      conflict_d       = 1'b0;
      conflict_slice_d = '0;
      conflict_drv_d   = '0;
      conflict_cnt_d   = '0;
      timeout_flag_d   = 1'b0;
    end
    if (any_conf_c) begin
      if (!conflict_d) conflict_drv_d = first_second_c;
      conflict_d       = 1'b1;
      conflict_slice_d = conflict_slice_d | slice_conf_c;
      if (conflict_cnt_d != '1) conflict_cnt_d = conflict_cnt_d + CNTW'(1);
    end
    if (timeout_d) timeout_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge crobar_l) begin
    if (!crobar_l) begin
      conflict_q       <= 1'b0;
      conflict_slice_q <= '0;
      conflict_drv_q   <= '0;
      conflict_cnt_q   <= '0;
      timeout_q        <= 1'b0;
      timeout_flag_q   <= 1'b0;
      wd_state_q       <= IDLE;
      wd_cnt_q         <= '0;
    end else begin
      conflict_q       <= conflict_d;
      conflict_slice_q <= conflict_slice_d;
      conflict_drv_q   <= conflict_drv_d;
      conflict_cnt_q   <= conflict_cnt_d;
      timeout_q        <= timeout_d;
      timeout_flag_q   <= timeout_flag_d;
      wd_state_q       <= wd_state_d;
      wd_cnt_q         <= wd_cnt_d;
    end
  end

  assign conflict       = conflict_q;
  assign conflict_slice = conflict_slice_q;
  assign conflict_drv   = conflict_drv_q;
  assign conflict_cnt   = conflict_cnt_q;
  assign timeout        = timeout_q;
  assign timeout_flag   = timeout_flag_q;

endmodule

// File: tb/tb_ebus_mux_arb.sv
// Directed bench for ebus_mux_arb: vector table for mux/status, hand
// sequences for saturation, watchdog and asynchronous reset.
module tb_ebus_mux_arb;

  localparam int unsigned NDRV   = 32;
  localparam int unsigned WIDTH  = 36;
  localparam int unsigned NSLICE = 6;

  logic                    clk;
  logic                    crobar_l;
  logic [NDRV*NSLICE-1:0]  drv_slice_en;
  logic [NDRV*WIDTH-1:0]   drv_data;
  logic                    demand;
  logic                    xfer;
  logic                    clr_status;
  logic [WIDTH-1:0]        ebus_data;
  logic [NSLICE-1:0]       ebus_driven;
  logic                    conflict;
  logic [NSLICE-1:0]       conflict_slice;
  logic [4:0]              conflict_drv;
  logic [7:0]              conflict_cnt;
  logic                    timeout;
  logic                    timeout_flag;

  ebus_mux_arb #(
    .NDRV    (NDRV),
    .WIDTH   (WIDTH),
    .NSLICE  (NSLICE),
    .REG_OUT (1),
    .TIMEOUT (4),
    .CNTW    (8)
  ) dut (
    .clk            (clk),
    .crobar_l       (crobar_l),
    .drv_slice_en   (drv_slice_en),
    .drv_data       (drv_data),
    .demand         (demand),
    .xfer           (xfer),
    .clr_status     (clr_status),
    .ebus_data      (ebus_data),
    .ebus_driven    (ebus_driven),
    .conflict       (conflict),
    .conflict_slice (conflict_slice),
    .conflict_drv   (conflict_drv),
    .conflict_cnt   (conflict_cnt),
    .timeout        (timeout),
    .timeout_flag   (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NDRV*NSLICE-1:0] en;
    logic [NDRV*WIDTH-1:0]  data;
    logic                   clr;
    logic [WIDTH-1:0]       e_data;
    logic [NSLICE-1:0]      e_driven;
    logic                   e_conf;
    logic [NSLICE-1:0]      e_cs;
    logic [4:0]             e_drv;
    logic [7:0]             e_cnt;
  } vec_t;

  vec_t                   vecs[$];
  logic [NDRV*NSLICE-1:0] cur_en;
  logic [NDRV*WIDTH-1:0]  cur_data;
  int                     checks;
  int                     errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rep(input int v);
    return {6{6'(v)}};
  endfunction

  task automatic add_drv(input int i, input logic [5:0] mask, input logic [35:0] word);
    for (int s = 0; s < 6; s++) cur_en[i*6 + s] = mask[s];
    cur_data[i*36 +: 36] = word;
  endtask

  task automatic push(input logic clr, input logic [35:0] d, input logic [5:0] drv,
                      input logic cf, input logic [5:0] cs, input logic [4:0] idx,
                      input logic [7:0] cnt);
    vec_t v;
    v.en = cur_en; v.data = cur_data; v.clr = clr;
    v.e_data = d; v.e_driven = drv; v.e_conf = cf; v.e_cs = cs; v.e_drv = idx; v.e_cnt = cnt;
    vecs.push_back(v);
    cur_en = '0;
    cur_data = '0;
  endtask

  task automatic apply_cur();
    drv_slice_en = cur_en;
    drv_data     = cur_data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " data"}, 64'(ebus_data), 0);
    chk({tag, " driven"}, 64'(ebus_driven), 0);
    chk({tag, " conflict"}, 64'(conflict), 0);
    chk({tag, " cslice"}, 64'(conflict_slice), 0);
    chk({tag, " cdrv"}, 64'(conflict_drv), 0);
    chk({tag, " ccnt"}, 64'(conflict_cnt), 0);
    chk({tag, " timeout"}, 64'(timeout), 0);
    chk({tag, " tflag"}, 64'(timeout_flag), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    crobar_l = 1'b0; drv_slice_en = '0; drv_data = '0;
    demand = 1'b0; xfer = 1'b0; clr_status = 1'b0;
    cur_en = '0; cur_data = '0;

    #3;
    chk_all_zero("reset");
    #9 crobar_l = 1'b1;
    step();

    // v0: nothing driven
    push(1'b0, 36'o0, 6'b000000, 1'b0, 6'b000000, 5'd0, 8'd0);
    // v1: slice assembly from drivers 10..15
    for (int k = 0; k < 6; k++) add_drv(10 + k, 6'(1 << k), 36'(k + 1) << (6 * (5 - k)));
    push(1'b0, 36'o010203040506, 6'b111111, 1'b0, 6'b000000, 5'd0, 8'd0);
    // v2: lone whole-word driver
    add_drv(5, 6'h3f, 36'o123456701234);
    push(1'b0, 36'o123456701234, 6'b111111, 1'b0, 6'b000000, 5'd0, 8'd0);
    // v3: priority 3 over 7 on every slice
    add_drv(3, 6'h3f, 36'o111111111111);
    add_drv(7, 6'h3f, 36'o777777777777);
    push(1'b0, 36'o111111111111, 6'b111111, 1'b1, 6'b111111, 5'd7, 8'd1);
    // v4: clear with a simultaneous slice-4 conflict
    add_drv(2, 6'b010000, 36'o252525252525);
    add_drv(9, 6'b010000, 36'o525252525252);
    push(1'b1, 36'o000000002500, 6'b010000, 1'b1, 6'b010000, 5'd9, 8'd1);
    // v5: plain clear
    push(1'b1, 36'o0, 6'b000000, 1'b0, 6'b000000, 5'd0, 8'd0);
    // v6: conflicts on slices 1 and 3; slice 1 selects the losing index
    add_drv(4, 6'b001000, rep(5));
    add_drv(6, 6'b001000, rep(7));
    add_drv(8, 6'b001000, rep(9));
    add_drv(12, 6'b000010, rep(13));
    add_drv(30, 6'b000010, rep(31));
    push(1'b0, 36'o001500050000, 6'b001010, 1'b1, 6'b001010, 5'd30, 8'd1);
    // v7: further conflict keeps the first losing index
    add_drv(0, 6'b000001, rep(1));
    add_drv(1, 6'b000001, rep(2));
    push(1'b0, 36'o010000000000, 6'b000001, 1'b1, 6'b001011, 5'd30, 8'd2);

    for (int k = 0; k < vecs.size(); k++) begin
      drv_slice_en = vecs[k].en;
      drv_data     = vecs[k].data;
      clr_status   = vecs[k].clr;
      step();
      clr_status = 1'b0;
      chk($sformatf("v%0d data", k), 64'(ebus_data), 64'(vecs[k].e_data));
      chk($sformatf("v%0d driven", k), 64'(ebus_driven), 64'(vecs[k].e_driven));
      chk($sformatf("v%0d conflict", k), 64'(conflict), 64'(vecs[k].e_conf));
      chk($sformatf("v%0d cslice", k), 64'(conflict_slice), 64'(vecs[k].e_cs));
      chk($sformatf("v%0d cdrv", k), 64'(conflict_drv), 64'(vecs[k].e_drv));
      chk($sformatf("v%0d ccnt", k), 64'(conflict_cnt), 64'(vecs[k].e_cnt));
    end

    // Registered output holds until the next edge, then saturation run.
    add_drv(3, 6'h3f, 36'o111111111111);
    add_drv(7, 6'h3f, 36'o777777777777);
    apply_cur();
    #1 chk("latency hold", 64'(ebus_data), 64'(36'o010000000000));
    repeat (100) step();
    chk("sat 102", 64'(conflict_cnt), 64'd102);
    chk("sat data", 64'(ebus_data), 64'(36'o111111111111));
    repeat (200) step();
    chk("sat 255", 64'(conflict_cnt), 64'd255);
    chk("sat cdrv held", 64'(conflict_drv), 64'd30);
    chk("sat cslice", 64'(conflict_slice), 64'(6'b111111));
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr+conf cnt", 64'(conflict_cnt), 64'd1);
    chk("clr+conf cdrv", 64'(conflict_drv), 64'd7);
    chk("clr+conf conflict", 64'(conflict), 64'd1);
    cur_en = '0; cur_data = '0;
    apply_cur();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk_all_zero("cleared");

    // Watchdog expiry with demand held.
    demand = 1'b1;
    step();
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("wd E%0d pulse", e), 64'(timeout), 0);
    end
    step();
    chk("wd E4 pulse", 64'(timeout), 1);
    chk("wd E4 flag", 64'(timeout_flag), 1);
    step();
    chk("wd E5 pulse", 64'(timeout), 0);
    chk("wd E5 flag", 64'(timeout_flag), 1);
    demand = 1'b0;
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("wd flag clr", 64'(timeout_flag), 0);

    // xfer on WAIT cycle 3, then re-arm after demand drops.
    demand = 1'b1;
    repeat (3) step();
    xfer = 1'b1;
    step();
    xfer = 1'b0;
    chk("xfer3 pulse", 64'(timeout), 0);
    for (int e = 0; e < 6; e++) begin
      step();
      chk($sformatf("xfer3 done %0d", e), 64'(timeout), 0);
    end
    chk("xfer3 flag", 64'(timeout_flag), 0);
    demand = 1'b0;
    step();
    demand = 1'b1;
    repeat (4) step();
    chk("rearm E3 pulse", 64'(timeout), 0);
    step();
    chk("rearm E4 pulse", 64'(timeout), 1);
    demand = 1'b0;
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;

    // xfer coincides with expiry.
    demand = 1'b1;
    repeat (4) step();
    xfer = 1'b1;
    step();
    xfer = 1'b0;
    chk("coinc pulse", 64'(timeout), 0);
    chk("coinc flag", 64'(timeout_flag), 0);
    step();
    chk("coinc after", 64'(timeout), 0);

    // Demand withdrawn mid-WAIT.
    demand = 1'b0;
    step();
    demand = 1'b1;
    repeat (2) step();
    demand = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      chk($sformatf("drop %0d", e), 64'(timeout), 0);
    end

    // Asynchronous reset mid-WAIT with an active conflict.
    add_drv(3, 6'h3f, 36'o111111111111);
    add_drv(7, 6'h3f, 36'o777777777777);
    apply_cur();
    step();
    chk("pre-rst conflict", 64'(conflict), 1);
    demand = 1'b1;
    repeat (2) step();
    #3 crobar_l = 1'b0;
    #1 chk_all_zero("async rst");
    cur_en = '0; cur_data = '0;
    apply_cur();
    demand = 1'b0;
    #2 crobar_l = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      chk($sformatf("post-rst pulse %0d", e), 64'(timeout), 0);
    end
    chk_all_zero("post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
